// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, widths, entry layout and deserializer state type
package fb_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int FRAC = 6;
  localparam int ADDR_W = 17;
  localparam int PIX_W = 16;
  localparam int COORD_W = PIX_W - FRAC;
  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} des_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0] colour;
  } fb_entry_t;
  // y*320 + x built from two shifts so no multiplier is inferred; wraps at 2^17
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] xi, input logic [COORD_W-1:0] yi);
    logic [ADDR_W-1:0] y;
    y = ADDR_W'(yi);
    return (y << 8) + (y << 6) + ADDR_W'(xi);
  endfunction
endpackage

// File: rtl/pixel_writer_if.sv
// pixel_writer_if: serial pixel stream in, framebuffer write port and status out
interface pixel_writer_if;
  import fb_pkg::*;
  logic START;
  logic HIT;
  logic PX;
  logic PY;
  logic C;
  logic TRI_DONE;
  logic FB_READY;
  logic FB_WE;
  logic [ADDR_W-1:0] FB_ADDR;
  logic [PIX_W-1:0] FB_DATA;
  logic TRI_ACK;
  logic OVF;
  modport master(output START, HIT, PX, PY, C, TRI_DONE, FB_READY,
                 input FB_WE, FB_ADDR, FB_DATA, TRI_ACK, OVF);
  modport slave(input START, HIT, PX, PY, C, TRI_DONE, FB_READY,
                output FB_WE, FB_ADDR, FB_DATA, TRI_ACK, OVF);
endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo: circular buffer of framebuffer entries exposing the head and the entry behind it
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      push,
  input  fb_entry_t din,
  input  logic      pop,
  output fb_entry_t head,
  output fb_entry_t next,
  output logic      full,
  output logic      empty,
  output logic      more
);
  localparam int AW = $clog2(DEPTH);
  fb_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] count;
  logic wr, rd;
  assign rd_nxt = rd_ptr + AW'(1);
  assign head = mem[rd_ptr];
  assign next = mem[rd_nxt];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign more = count[AW:1] != '0;
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  // storage needs no reset: only slots between the pointers are ever read
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd ? rd_nxt : rd_ptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: deserialize hit pixels, buffer them and stream writes to the framebuffer (PIXEL_WRITER_CLIP_EN drops off-screen pixels)
module pixel_writer
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic CLK,
  input logic RST,
  pixel_writer_if.slave bus
);
  des_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [PIX_W-1:0] sx, sy, sc;
  logic [COORD_W-1:0] xi, yi;
  logic hit_r, shift_en, keep, push_req, fifo_push, drop;
  logic pop, load, nxt_valid, full, empty, more;
  logic fb_we, ovf, pending, ack;
  fb_entry_t entry, head, next, nxt_entry, out_r;
  assign xi = sx[PIX_W-1:FRAC];
  assign yi = sy[PIX_W-1:FRAC];
  assign entry = '{addr: lin_addr(xi, yi), colour: sc};
`ifdef PIXEL_WRITER_CLIP_EN
  assign keep = hit_r && !sx[PIX_W-1] && !sy[PIX_W-1] && xi < COORD_W'(FB_W) && yi < COORD_W'(FB_H);
`else
  assign keep = hit_r;
`endif
  // deserializer state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state_nxt;
  end
  // IDLE and PUSH both accept a new START, SHIFT ignores it for 15 cycles
  always_comb begin
    shift_en = state == SHIFT || (bus.START && state != SHIFT);
    push_req = state == PUSH && keep;
    state_nxt = state == SHIFT ? (cnt == 4'd14 ? PUSH : SHIFT) : (bus.START ? SHIFT : IDLE);
  end
  // MSB-first shift registers; 16 shifts fully replace the previous word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      sx <= '0;
      sy <= '0;
      sc <= '0;
      hit_r <= 1'b0;
    end else begin
      cnt <= state == SHIFT ? cnt + 4'd1 : 4'd0;
      if (shift_en) begin
        sx <= {sx[PIX_W-2:0], bus.PX};
        sy <= {sy[PIX_W-2:0], bus.PY};
        sc <= {sc[PIX_W-2:0], bus.C};
      end
      if (bus.START && state != SHIFT) hit_r <= bus.HIT;
    end
  end
  // an entry stays in the FIFO until its write is accepted, so a pop frees room the same cycle
  assign pop = fb_we && bus.FB_READY;
  assign fifo_push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .push(fifo_push),
    .din(entry),
    .pop(pop),
    .head(head),
    .next(next),
    .full(full),
    .empty(empty),
    .more(more)
  );
  assign load = !fb_we || bus.FB_READY;
  assign nxt_valid = pop ? more : !empty;
  assign nxt_entry = pop ? next : head;
  // output register mirrors the FIFO head and holds while the framebuffer stalls
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fb_we <= 1'b0;
      out_r <= '0;
    end else if (load) begin
      fb_we <= nxt_valid;
      if (nxt_valid) out_r <= nxt_entry;
    end
  end
  // sticky overflow and the pending-triangle flag; repeated TRI_DONE collapses into one ack
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf <= 1'b0;
      pending <= 1'b0;
    end else begin
      ovf <= ovf || drop;
      pending <= ack ? 1'b0 : (pending || bus.TRI_DONE);
    end
  end
  assign ack = pending && state == IDLE && empty && !fb_we;
  assign bus.FB_WE = fb_we;
  assign bus.FB_ADDR = out_r.addr;
  assign bus.FB_DATA = out_r.colour;
  assign bus.TRI_ACK = ack;
  assign bus.OVF = ovf;
endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of deserialized pixel entries buffered; it SHALL be a power of two, 2..16.
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  one-cycle strobe; coincides with bit 15 (MSB) of PX/PY/C.
REQ-005 HIT  in  1  sampled with START; 1 = pixel inside triangle, 0 = background.
REQ-006 PX, PY, C  in  1 each  serial Q10.6 x, Q10.6 y, RGB565 colour; MSB first, one bit per cycle.
REQ-007 TRI_DONE  in  1  one-cycle pulse: the current triangle has no further pixels.
REQ-008 FB_READY  in  1  framebuffer accepts a write this cycle.
REQ-009 FB_WE  out  1  write request; transfer when FB_WE && FB_READY.
REQ-010 FB_ADDR  out  17  linear address y*320 + x.
REQ-011 FB_DATA  out  16  pixel colour.
REQ-012 TRI_ACK  out  1  one-cycle pulse: triangle fully written.
REQ-013 OVF  out  1  sticky: a pixel was dropped because the FIFO was full.

Function
REQ-014 Deserializer FSM SHALL have states IDLE, SHIFT, PUSH; IDLE->SHIFT on START, capturing bit 15 and HIT.
REQ-015 SHIFT SHALL capture bits 14..0 on the next 15 cycles, then go to PUSH; START during SHIFT SHALL be ignored.
REQ-016 PUSH SHALL last one cycle, form the entry and return to IDLE; START in the PUSH cycle SHALL begin a new word (back-to-back words every 16 cycles supported).
REQ-017 Integer coordinates SHALL be xi = PX[15:6], yi = PY[15:6]; the fraction is discarded (truncation).
REQ-018 Pixels with HIT=0 SHALL be discarded in PUSH and not enter the FIFO.
REQ-019 Address SHALL be computed as (yi<<8)+(yi<<6)+xi in 17 bits, no multiplier.
REQ-020 If the FIFO is full in PUSH, the pixel SHALL be dropped and OVF set; OVF clears only on RST.
REQ-021 Simultaneous push and pop on a full FIFO SHALL succeed without drop; on an empty FIFO, push SHALL NOT bypass to the outputs that cycle.
REQ-022 FB_WE/FB_ADDR/FB_DATA SHALL be registered from the FIFO head; they SHALL hold stable while FB_WE && !FB_READY.
REQ-023 Latency SHALL be: entry visible on FB_* 2 cycles after PUSH with an empty FIFO and FB_READY=1.
REQ-024 TRI_DONE SHALL set a pending flag; TRI_ACK SHALL pulse the first cycle the pending flag is set, deserializer is IDLE, FIFO is empty and no write is outstanding; then the flag clears.
REQ-025 TRI_DONE arriving while the flag is already pending SHALL be absorbed (one TRI_ACK).

Reset
REQ-026 On RST: FSM=IDLE, FIFO empty, FB_WE=0, FB_ADDR=0, FB_DATA=0, TRI_ACK=0, OVF=0, pending flag=0.
REQ-027 RST mid-word or mid-write SHALL discard all buffered pixels; no write SHALL be issued after RST deasserts until a new word completes.

Configuration
REQ-028 Macro PIXEL_WRITER_CLIP_EN defined: pixels with PX[15]=1, PY[15]=1, xi>=320 or yi>=240 SHALL be discarded in PUSH (not counted as overflow).
REQ-029 Macro undefined: no clipping; out-of-range addresses SHALL be written truncated to 17 bits.

Structure
REQ-030 Package fb_pkg SHALL hold FB_W=320, FB_H=240, FRAC=6, ADDR_W=17, PIX_W=16 and the FSM state typedef.
REQ-031 The FIFO SHALL be a separate sub-module pixel_fifo (data {addr,colour}, full/empty, simultaneous push/pop).

Verification
REQ-032 START, HIT=1, PX=0x0A40 (x=41), PY=0x0300 (y=12), C=0xF800, FB_READY=1 -> one write, FB_ADDR=3881, FB_DATA=0xF800, 18 cycles after START.
REQ-033 Same word with HIT=0 -> no FB_WE; following TRI_DONE -> TRI_ACK next eligible cycle.
REQ-034 FB_READY=0, 6 hit words back-to-back, FIFO_DEPTH=4 -> 4 held (one at outputs stable), later words dropped, OVF=1; release FB_READY -> buffered pixels written in order.
REQ-035 With CLIP_EN, PX=0x5000 (x=320) HIT=1 -> no write, OVF=0; without CLIP_EN -> write at address (yi*320+320) mod 2^17.
REQ-036 RST asserted at bit 7 of a word with 2 pixels buffered -> all outputs 0 next cycle, no write after release.
